key_press_classifier: RTL and testbench
=======================================

// Module: key_press_classifier
// PURPOSE
//  Sits between key_filter (debounced key) and led_flash inside led_top.
//  Measures how long the debounced key is held and classifies each press as SHORT/MID/LONG.
//  On release, issues a one-cycle flash_start with a flash count.
//  Stays busy until led_flash returns flash_done; presses made while busy are discarded.
// PARAMETERS
//  T_MID   default 32'd50_000_000   cycles held for MID (1 s @ 50 MHz)
//  T_LONG  default 32'd100_000_000  cycles held for LONG (2 s @ 50 MHz); T_LONG > T_MID > 0
//  N_SHORT default 4'd1             flash count for a SHORT press
//  N_MID   default 4'd2             flash count for a MID press
//  N_LONG  default 4'd4             flash count for a LONG press
// PORTS
//  clk         in   1   system clock, 50 MHz
//  rst_n       in   1   asynchronous active-low reset
//  key_flag    in   1   1-cycle pulse from key_filter on every debounced edge
//  key_state   in   1   debounced key level; 0 = pressed, 1 = released
//  flash_done  in   1   1-cycle pulse from led_flash when its sequence ends
//  flash_start out  1   1-cycle request to led_flash
//  flash_num   out  4   flash count; valid from flash_start, held until the next start
//  press_class out  2   last class: 0 none, 1 SHORT, 2 MID, 3 LONG
//  busy        out  1   high from flash_start until flash_done is accepted
// BEHAVIOUR
//  Reset: FSM=IDLE, dur_cnt=0; flash_start, flash_num, press_class, busy all 0.
//  Press event = key_flag & ~key_state; release event = key_flag & key_state.
//  FSM states: IDLE, HOLD, FIRE, WAIT.
//   IDLE -> HOLD on a press event; dur_cnt loads 1.
//     A release event or flash_done in IDLE is ignored.
//   HOLD: dur_cnt += 1 each cycle; it saturates at T_LONG and never wraps.
//     On a release event, D = dur_cnt at that cycle. Register:
//       D < T_MID          -> SHORT
//       T_MID <= D < T_LONG -> MID
//       D >= T_LONG        -> LONG
//     Load flash_num and press_class for that class, then go to FIRE.
//     A second press event in HOLD is ignored (it cannot occur from key_filter).
//   FIRE: flash_start = 1 for exactly this cycle; busy goes 1; go to WAIT.
//   WAIT: busy = 1. On flash_done: busy -> 0, go to IDLE.
//     Press and release events in WAIT are discarded.
//     The release of a discarded press never triggers a flash.
//   flash_done in the same cycle as a press event in WAIT: go to IDLE, press discarded.
//     The key must be released and pressed again to start a new measurement.
//  Latency: release event at cycle t -> flash_start high at cycle t+1.
//  No handshake beyond start/done. The module never issues a second start before flash_done.
//  Reset asserted mid-HOLD or mid-WAIT: everything returns to reset values immediately, with no start pulse.
//  Counter width is 32 bits. Comparisons are unsigned.
// STRUCTURE
//  Shared package key_pkg: class encodings (CLS_NONE=0 .. CLS_LONG=3), FSM state localparams,
//   default T_MID/T_LONG for 50 MHz.
//  One sub-module: dur_counter.
//   Ports: clk, rst_n, clr, en, cnt[31:0].
//   32-bit up counter with clear (loads 1), enable, and saturation at parameter MAX.
//  Classifier FSM and output registers live in the top of this file.
// TESTING (override T_MID=100, T_LONG=200; 20 ns clock)
//  1 Hold 50 cycles, release -> flash_start 1 cycle after release; flash_num=1, press_class=1, busy=1.
//  2 Hold 150 and 200 cycles -> num=2/cls=2 and num=4/cls=3. Holding 99 -> SHORT; holding 100 -> MID (boundary).
//  3 Hold 10_000 cycles -> counter stuck at 200; num=4. No wrap.
//  4 Press and release in WAIT, then flash_done -> no flash_start; busy falls the cycle after done; next press works.
//  5 flash_done coincident with a press event in WAIT -> IDLE; that press's release gives no start.
//  6 rst_n low during HOLD -> all outputs 0 at once. After reset, a stray release event -> no start.
//  Checker on every test: flash_start width is 1 cycle. At most one start per flash_done.

Source files
------------

// File: rtl/key_pkg.sv
// Shared encodings and defaults for the key press classifier.
package key_pkg;

    localparam int unsigned CNT_W = 32;
    localparam int unsigned NUM_W = 4;
    localparam int unsigned CLS_W = 2;

    localparam logic [CLS_W-1:0] CLS_NONE  = 2'd0;
    localparam logic [CLS_W-1:0] CLS_SHORT = 2'd1;
    localparam logic [CLS_W-1:0] CLS_MID   = 2'd2;
    localparam logic [CLS_W-1:0] CLS_LONG  = 2'd3;

    // Hold thresholds for a 50 MHz clock: 1 s and 2 s.
    localparam logic [CNT_W-1:0] T_MID_50M  = 32'd50_000_000;
    localparam logic [CNT_W-1:0] T_LONG_50M = 32'd100_000_000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_FIRE = 2'd2,
        ST_WAIT = 2'd3
    } state_e;

    function automatic logic [CLS_W-1:0] classify(
        input logic [CNT_W-1:0] d,
        input logic [CNT_W-1:0] t_mid,
        input logic [CNT_W-1:0] t_long
    );
        if (d >= t_long)     return CLS_LONG;
        else if (d >= t_mid) return CLS_MID;
        else                 return CLS_SHORT;
    endfunction

endpackage

// File: rtl/dur_counter.sv
// Hold-duration counter: clear loads 1, enable counts up, saturates at MAX.
module dur_counter
    import key_pkg::*;
#(
    parameter logic [CNT_W-1:0] MAX = T_LONG_50M
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = CNT_W'(1);
        end else if (en && (cnt_q < MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/key_press_classifier.sv
// Classifies debounced key presses by hold time and requests a matching LED flash sequence.
module key_press_classifier
    import key_pkg::*;
#(
    parameter logic [CNT_W-1:0] T_MID   = T_MID_50M,
    parameter logic [CNT_W-1:0] T_LONG  = T_LONG_50M,
    parameter logic [NUM_W-1:0] N_SHORT = 4'd1,
    parameter logic [NUM_W-1:0] N_MID   = 4'd2,
    parameter logic [NUM_W-1:0] N_LONG  = 4'd4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_flag,
    input  logic             key_state,
    input  logic             flash_done,
    output logic             flash_start,
    output logic [NUM_W-1:0] flash_num,
    output logic [CLS_W-1:0] press_class,
    output logic             busy
);

    state_e           state_q, state_d;
    logic             flash_start_q, flash_start_d;
    logic [NUM_W-1:0] flash_num_q, flash_num_d;
    logic [CLS_W-1:0] press_class_q, press_class_d;
    logic             busy_q, busy_d;

    logic             cnt_clr;
    logic             cnt_en;
    logic [CNT_W-1:0] dur_cnt;
    logic             press_ev;
    logic             release_ev;
    logic [CLS_W-1:0] cls_now;

    assign press_ev   = key_flag & ~key_state;
    assign release_ev = key_flag &  key_state;
    assign cls_now    = classify(dur_cnt, T_MID, T_LONG);

    dur_counter #(
        .MAX (T_LONG)
    ) u_dur_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .cnt   (dur_cnt)
    );

    // Next-state and output-register logic.
    always_comb begin
        state_d       = state_q;
        flash_start_d = 1'b0;
        flash_num_d   = flash_num_q;
        press_class_d = press_class_q;
        busy_d        = busy_q;
        cnt_clr       = 1'b0;
        cnt_en        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (press_ev) begin
                    cnt_clr = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                cnt_en = 1'b1;
                if (release_ev) begin
                    press_class_d = cls_now;
                    case (cls_now)
                        CLS_SHORT: flash_num_d = N_SHORT;
                        CLS_MID:   flash_num_d = N_MID;
                        default:   flash_num_d = N_LONG;
                    endcase
                    flash_start_d = 1'b1;
                    busy_d        = 1'b1;
                    state_d       = ST_FIRE;
                end
            end
            ST_FIRE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A press landing with flash_done is dropped; IDLE only reacts to a fresh press.
                if (flash_done) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            flash_start_q <= 1'b0;
            flash_num_q   <= '0;
            press_class_q <= CLS_NONE;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            flash_start_q <= flash_start_d;
            flash_num_q   <= flash_num_d;
            press_class_q <= press_class_d;
            busy_q        <= busy_d;
        end
    end

    assign flash_start = flash_start_q;
    assign flash_num   = flash_num_q;
    assign press_class = press_class_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_key_press_classifier.sv
// Randomized bench for key_press_classifier against a cycle-count reference model.
module tb_key_press_classifier;

    localparam logic [31:0] TM = 32'd100;
    localparam logic [31:0] TL = 32'd200;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_flag = 1'b0;
    logic       key_state = 1'b1;
    logic       flash_done = 1'b0;
    logic       flash_start;
    logic [3:0] flash_num;
    logic [1:0] press_class;
    logic       busy;

    int n_checks = 0;
    int n_err    = 0;

    key_press_classifier #(
        .T_MID   (TM),
        .T_LONG  (TL),
        .N_SHORT (4'd1),
        .N_MID   (4'd2),
        .N_LONG  (4'd4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_flag    (key_flag),
        .key_state   (key_state),
        .flash_done  (flash_done),
        .flash_start (flash_start),
        .flash_num   (flash_num),
        .press_class (press_class),
        .busy        (busy)
    );

    always #10 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: elapsed-cycle arithmetic on press/release times.
    int unsigned cyc = 0;
    int unsigned press_cyc = 0;
    int unsigned start_cyc = 0;
    bit          holding = 1'b0;
    bit          e_start = 1'b0;
    bit          e_busy  = 1'b0;
    logic [3:0]  e_num   = 4'd0;
    logic [1:0]  e_cls   = 2'd0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            holding = 1'b0;
            e_start = 1'b0;
            e_busy  = 1'b0;
            e_num   = 4'd0;
            e_cls   = 2'd0;
        end else begin
            int unsigned d;
            cyc++;
            e_start = 1'b0;
            if (e_busy) begin
                // Done is honoured from the second cycle after the start pulse onward.
                if (flash_done && cyc >= start_cyc + 2) e_busy = 1'b0;
            end else if (holding) begin
                if (key_flag && key_state) begin
                    d = cyc - press_cyc;
                    if (d > TL) d = TL;
                    if (d >= TL)      begin e_cls = 2'd3; e_num = 4'd4; end
                    else if (d >= TM) begin e_cls = 2'd2; e_num = 4'd2; end
                    else              begin e_cls = 2'd1; e_num = 4'd1; end
                    e_start   = 1'b1;
                    e_busy    = 1'b1;
                    start_cyc = cyc;
                    holding   = 1'b0;
                end
            end else if (key_flag && !key_state) begin
                holding   = 1'b1;
                press_cyc = cyc;
            end
        end
    end

    // Compare process: every cycle, plus start-width and one-start-per-done checks.
    bit prev_start = 1'b0;
    bit start_open = 1'b0;
    always @(negedge clk) begin
        chk("flash_start", 32'(flash_start), 32'(e_start));
        chk("flash_num",   32'(flash_num),   32'(e_num));
        chk("press_class", 32'(press_class), 32'(e_cls));
        chk("busy",        32'(busy),        32'(e_busy));
        if (flash_start) begin
            chk("start_width",    32'(prev_start), 32'd0);
            chk("start_per_done", 32'(start_open), 32'd0);
            start_open = 1'b1;
        end else if (!busy) begin
            start_open = 1'b0;
        end
        prev_start = flash_start;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic key_edge(input logic lvl);
        key_state = lvl;
        key_flag  = 1'b1;
        @(negedge clk);
        key_flag  = 1'b0;
    endtask

    task automatic hold(input int n);
        key_edge(1'b0);
        cycles(n - 1);
        key_edge(1'b1);
    endtask

    task automatic pulse_done();
        flash_done = 1'b1;
        @(negedge clk);
        flash_done = 1'b0;
    endtask

    task automatic finish_flash();
        cycles(int'($urandom_range(1, 4)));
        pulse_done();
        chk("busy_after_done", 32'(busy), 32'd0);
    endtask

    task automatic hold_expect(input string name, input int n, input logic [3:0] num, input logic [1:0] cls);
        hold(n);
        chk({name, "_start"}, 32'(flash_start), 32'd1);
        chk({name, "_num"},   32'(flash_num),   32'(num));
        chk({name, "_cls"},   32'(press_class), 32'(cls));
        chk({name, "_busy"},  32'(busy),        32'd1);
        finish_flash();
    endtask

    initial begin
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        cycles(2);
        chk("rst_start", 32'(flash_start), 32'd0);
        chk("rst_busy",  32'(busy),        32'd0);
        chk("rst_cls",   32'(press_class), 32'd0);
        rst_n = 1'b1;
        cycles(3);

        // Basic classes and thresholds.
        hold_expect("short50",  50,  4'd1, 2'd1);
        hold_expect("mid150",   150, 4'd2, 2'd2);
        hold_expect("long200",  200, 4'd4, 2'd3);
        hold_expect("short99",  99,  4'd1, 2'd1);
        hold_expect("mid100",   100, 4'd2, 2'd2);
        hold_expect("long199",  199, 4'd2, 2'd2);

        // Very long hold saturates the counter.
        key_edge(1'b0);
        cycles(9999);
        chk("sat_cnt", dut.dur_cnt, 32'd200);
        key_edge(1'b1);
        chk("sat_num", 32'(flash_num), 32'd4);
        finish_flash();

        // Press and release while busy are discarded.
        hold(30);
        cycles(1);
        hold(5);
        cycles(3);
        pulse_done();
        chk("wait_busy_fall", 32'(busy), 32'd0);
        hold_expect("after_wait", 60, 4'd1, 2'd1);

        // flash_done coincident with a press: press discarded.
        hold(120);
        cycles(2);
        key_state  = 1'b0;
        key_flag   = 1'b1;
        flash_done = 1'b1;
        @(negedge clk);
        key_flag   = 1'b0;
        flash_done = 1'b0;
        cycles(10);
        key_edge(1'b1);
        chk("coinc_no_start", 32'(flash_start), 32'd0);
        chk("coinc_busy",     32'(busy),        32'd0);
        hold_expect("after_coinc", 10, 4'd1, 2'd1);

        // Reset in the middle of a hold.
        key_edge(1'b0);
        cycles(20);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_start", 32'(flash_start), 32'd0);
        chk("midrst_num",   32'(flash_num),   32'd0);
        chk("midrst_cls",   32'(press_class), 32'd0);
        chk("midrst_busy",  32'(busy),        32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cycles(2);
        key_edge(1'b1);
        cycles(3);
        chk("stray_rel_busy", 32'(busy), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 4) == 0) pulse_done();
            hold(int'($urandom_range(1, 260)));
            if ($urandom_range(0, 2) == 0) begin
                cycles(int'($urandom_range(0, 3)));
                hold(int'($urandom_range(1, 8)));
            end
            finish_flash();
            cycles(int'($urandom_range(0, 5)));
        end

        cycles(5);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
